axi_lite_reg_slave: RTL and testbench

//   AXI-Lite responder (slave end) fronting a bank of NUM_REGS read/write registers.

---
 rtl/axi_lite_reg_slave.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register target: NUM_REGS byte-strobed CSRs with AW/W in any order,
// one outstanding write response and one outstanding read, contents exported flat.

// One storage register with byte-lane merge on write.
module axi_lite_reg_cell #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic [DW/8-1:0] wstrb,
  output logic [DW-1:0] q
);
  logic [DW-1:0] val_q, val_d;

  // Merge strobed bytes into the current value when this register is written.
  always_comb begin
    val_d = val_q;
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wstrb[b]) val_d[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  // Storage flop.
  always_ff @(posedge clk) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign q = val_q;
endmodule

module axi_lite_reg_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           wvalid,
  output logic                           wready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [1:0]                     bresp,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [1:0]                     rresp,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr
);
  localparam int STRB_W = DATA_WIDTH/8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Address decode: byte offset from base, word index, range check. Low two bits ignored.
  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr);
    dec_t                  r;
    logic [ADDR_WIDTH-1:0] off;
    off   = addr - BASE_ADDR;
    r.hit = (addr >= BASE_ADDR) && ((off >> 2) < ADDR_WIDTH'(NUM_REGS));
    r.idx = off[IDX_W+1:2];
    return r;
  endfunction

  // Protection bits carry no meaning for this target.
  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  logic                  areset_q;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   reg_wr_q, reg_wr_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                 reg_we;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  dec_t                  wr_dec, rd_dec;
  logic [DATA_WIDTH-1:0] rd_val;

  assign awready = !aw_held_q && !bvalid_q && !areset_q;
  assign wready  = !w_held_q  && !bvalid_q && !areset_q;
  assign arready = !rvalid_q  && !areset_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign ar_hs = arvalid && arready;

  // A channel that handshakes this edge is used directly, so AW+W together commit at once.
  assign wr_addr = aw_held_q ? awaddr_q : awaddr;
  assign wr_data = w_held_q  ? wdata_q  : wdata;
  assign wr_strb = w_held_q  ? wstrb_q  : wstrb;
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_dec  = decode(wr_addr);
  assign rd_dec  = decode(araddr);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign reg_we[gi] = commit && wr_dec.hit && (wr_dec.idx == IDX_W'(gi));
      axi_lite_reg_cell #(.DW(DATA_WIDTH)) u_cell (
        .clk   (aclk),
        .rst   (areset),
        .we    (reg_we[gi]),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .q     (regs[gi])
      );
    end
  endgenerate

  // Read mux over the register bank (pre-write values on a same-edge commit).
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_dec.idx == IDX_W'(i)) rd_val = regs[i];
    end
  end

  // Write path: capture AW/W independently, commit when both present, hold B until taken.
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    reg_wr_d  = '0;
    if (bvalid_q && bready) bvalid_d = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_dec.hit ? RESP_OKAY : RESP_SLVERR;
      reg_wr_d  = reg_we;
    end
  end

  // Read path: single outstanding read, response held until taken.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_dec.hit ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rd_dec.hit ? rd_val : '0;
    end
  end

  // State registers; reset discards any pending request without a response.
  always_ff @(posedge aclk) begin
    areset_q <= areset;
    if (areset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      reg_wr_q  <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      reg_wr_q  <= reg_wr_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rresp  = rresp_q;
  assign rdata  = rdata_q;
  assign reg_wr = reg_wr_q;
  assign reg_q  = regs;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed plus randomized bench for axi_lite_reg_slave against a word-array model.
module tb_axi_lite_reg_slave;
  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h0;

  logic          aclk = 1'b0;
  logic          areset;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   awaddr, araddr, wdata, rdata;
  logic [2:0]    awprot, arprot;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0] reg_wr;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NR];

  always #5 aclk = ~aclk;

  axi_lite_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
    .reg_q(reg_q), .reg_wr(reg_wr)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < 4 * NR);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  task automatic chk_regs(input string tag);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s reg_q[%0d]", tag, i), reg_q[i*32 +: 32], model[i]);
  endtask

  // Drive AW after awd cycles and W after wd cycles, then check B and the bank; hold bready low bd cycles.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int awd, input int wd, input int bd);
    bit aw_done, w_done, afire, wfire, hit;
    int cyc, idx;
    logic [1:0] exp_resp;
    logic [NR-1:0] exp_wr;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= awd);
      wvalid  = !w_done && (cyc >= wd);
      afire = awvalid && awready;
      wfire = wvalid && wready;
      tick();
      cyc++;
      if (afire) aw_done = 1;
      if (wfire) w_done = 1;
      awvalid = 0; wvalid = 0;
      if (!(aw_done && w_done)) begin
        chk("no_early_b", bvalid, 0);
        if (aw_done) chk("awready_drop", awready, 0);
        if (w_done)  chk("wready_drop", wready, 0);
      end
    end
    chk("write_hs_done", aw_done && w_done, 1);
    hit = m_hit(addr);
    idx = hit ? m_idx(addr) : 0;
    exp_resp = hit ? 2'b00 : 2'b10;
    exp_wr = hit ? (NR'(1) << idx) : '0;
    chk("b_latency", bvalid, 1);
    chk("bresp", bresp, exp_resp);
    chk("reg_wr", reg_wr, exp_wr);
    if (hit)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    chk_regs("wr");
    for (int k = 0; k < bd; k++) begin
      tick();
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp, exp_resp);
      chk("aw_w_blocked", {awready, wready}, 0);
    end
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_clear", bvalid, 0);
    chk("reg_wr_one_cycle", reg_wr, 0);
    chk("aw_w_ready_back", {awready, wready}, 2'b11);
  endtask

  // Issue AR, check R against the model, hold rready low rd cycles.
  task automatic axi_read(input logic [31:0] addr, input int rd);
    bit fire, hit;
    int cyc;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    fire = 0; cyc = 0;
    araddr = addr;
    arvalid = 1;
    while (!fire && cyc < 50) begin
      fire = arready;
      tick();
      cyc++;
    end
    arvalid = 0;
    chk("ar_hs_done", fire, 1);
    hit = m_hit(addr);
    exp_data = hit ? model[m_idx(addr)] : 32'h0;
    exp_resp = hit ? 2'b00 : 2'b10;
    chk("r_latency", rvalid, 1);
    chk("rdata", rdata, exp_data);
    chk("rresp", rresp, exp_resp);
    for (int k = 0; k < rd; k++) begin
      tick();
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", rdata, exp_data);
      chk("rresp_hold", rresp, exp_resp);
      chk("arready_blocked", arready, 0);
    end
    rready = 1;
    tick();
    rready = 0;
    chk("rvalid_clear", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  initial begin
    logic [31:0] old3;
    areset = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 3'b010; arprot = 3'b001;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    // Reset state and ready release timing
    tick(); tick();
    areset = 0;
    chk("rst_readys_low", {awready, wready, arready}, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp_rresp", {bresp, rresp}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_reg_wr", reg_wr, 0);
    chk_regs("rst");
    tick();
    chk("rst_readys_up", {awready, wready, arready}, 3'b111);

    // Same-cycle AW+W
    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    chk("reg1_const", reg_q[32 +: 32], 32'hDEADBEEF);

    // W first, AW three cycles later, partial strobe
    axi_write(32'h8, 32'h11223344, 4'b0101, 3, 0, 0);
    chk("reg2_const", reg_q[64 +: 32], 32'h00220044);

    // Out-of-range accesses
    axi_read(32'h40, 0);
    axi_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);

    // Backpressure on B and R, zero strobe, unaligned low bits
    axi_write(32'h1B, 32'h0BADC0DE, 4'hF, 1, 2, 5);
    axi_write(32'h18, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    axi_read(32'h19, 5);
    axi_read(32'h4, 0);

    // AR on the same edge as a commit to the same register returns the old value
    old3 = model[3];
    awaddr = 32'hC; wdata = 32'hA5; wstrb = 4'hF; araddr = 32'hC;
    awvalid = 1; wvalid = 1; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("same_edge_rvalid", rvalid, 1);
    chk("same_edge_rdata_old", rdata, old3);
    chk("same_edge_bvalid", bvalid, 1);
    model[3] = 32'hA5;
    chk("same_edge_reg3", reg_q[96 +: 32], 32'hA5);
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    axi_read(32'hC, 0);

    // Reset with AW held and a read response pending
    awaddr = 32'h10; araddr = 32'h4; awvalid = 1; arvalid = 1;
    tick();
    awvalid = 0; arvalid = 0;
    chk("pre_rst_rvalid", rvalid, 1);
    chk("pre_rst_aw_held", awready, 0);
    areset = 1;
    tick();
    areset = 0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    chk("post_rst_rvalid", rvalid, 0);
    chk("post_rst_bvalid", bvalid, 0);
    chk("post_rst_readys_low", {awready, wready, arready}, 0);
    chk_regs("post_rst");
    tick();
    chk("post_rst_readys_up", {awready, wready, arready}, 3'b111);
    // A lone W must not pair with the discarded AW
    axi_write(32'h14, 32'h5A5A1234, 4'hF, 4, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFF0 | $urandom_range(0, 15);
      else a = ($urandom_range(0, NR + 3) * 4) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 3));
    end
    chk_regs("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
